ddram_arbiter: RTL and testbench
================================

# ddram_arbiter

Two-client arbiter and sequencer in front of the 8-bit `ddram` cache/port block.
- Accepts byte read/write requests from client A (CPU) and client B (DMA/video fetch), each using a toggle handshake.
- Grants one request at a time and drives the `ddram` toggle-write and edge-read handshakes.
- Returns read data per client.
- Invalidates the `ddram` line cache when a write hits a cached line, because `ddram` does not update its cache on writes.
- Sits between the Multicomp bus clients and `ddram`, all on `DDRAM_CLK`.

## Interface
Parameters:
- `FIXED_PRIO`, default 0: 0 = round-robin; 1 = A always wins simultaneous requests.
- `INV_ENABLE`, default 1: 1 = issue `cache_inv` on write to a cached line; 0 = never.

Ports:
- `DDRAM_CLK` in 1: single clock for the whole block.
- `reset` in 1: asynchronous, active-high; clears all state.
- `a_addr` in 28: client A byte address.
- `a_din` in 8: client A write data.
- `a_we` in 1: client A operation; 1 = write, 0 = read.
- `a_req` in 1: client A request toggle.
- `a_ack` out 1: client A ack toggle; equals `a_req` when done.
- `a_dout` out 8: client A registered read data.
- `b_addr`, `b_din`, `b_we`, `b_req`, `b_ack`, `b_dout`: identical set for client B.
- `ram_wraddr` out 28, `ram_din` out 8: to `ddram` `wraddr`/`din`.
- `ram_we_req` out 1 / `ram_we_ack` in 1: `ddram` write toggle pair.
- `ram_rdaddr` out 28 / `ram_rd_req` out 1: `ddram` read address / read-request level.
- `ram_rd_rdy` in 1, `ram_dout` in 8: `ddram` read-ready and combinational read data.
- `cache_inv` out 1: one-cycle pulse; OR'd with system reset into `ddram` `reset`.

## Operation
- A client is pending when `x_req != x_ack`. Its `x_addr`, `x_din` and `x_we` must be held stable until `x_ack` toggles.
- Grant in IDLE:
  - Only one client pending: grant it.
  - Both pending, `FIXED_PRIO=1`: grant A.
  - Both pending, round-robin: grant the client not served last. `last` resets to B, so A wins first.
- On grant, latch client id, address, data and we into the `cur_*` registers. Drive `ram_wraddr` and `ram_rdaddr` from `cur_addr`; both stay stable through the access.
- States:
  - IDLE: on grant of a write, set `ram_din`, toggle `ram_we_req`, go to WR. On grant of a read, set `ram_rd_req=1`, go to RD_LO.
  - WR: wait for `ram_we_ack == ram_we_req`. Then toggle the granted `x_ack`. If `INV_ENABLE`, `lr_valid`, and `cur_addr[27:3]` is `lr_line` or `lr_line+1` (25-bit wrap), go to INV; otherwise go to IDLE.
  - INV: `cache_inv=1` for one cycle, clear `lr_valid`, go to IDLE.
  - RD_LO: wait for `ram_rd_rdy==0`, then `ram_rd_req<=0`, go to RD_HI.
  - RD_HI: wait for `ram_rd_rdy==1`. Capture `ram_dout` into the granted `x_dout`, toggle `x_ack`, set `lr_line<=cur_addr[27:3]` and `lr_valid<=1`, go to IDLE.
- Only the granted client's `x_dout` is updated. The other client's `x_dout` holds.
- Requests arriving mid-access wait. A client's own re-toggle while pending is illegal and is not checked.
- Reset mid-access:
  - All state returns to reset values.
  - An in-flight client request is left un-acked only if the client also resets. Clients share `reset`.

## Timing
- Reset values:
  - `a_ack`, `b_ack`, `ram_we_req`, `ram_rd_req`, `cache_inv`, `lr_valid` = 0.
  - `a_dout`, `b_dout`, `ram_wraddr`, `ram_rdaddr`, `ram_din` = 0.
  - State = IDLE.
- Grant latency: request toggle seen in cycle t → `ram_we_req` toggle or `ram_rd_req` rise at t+1.
- Write latency: `x_ack` toggles 1 cycle after `ram_we_ack` matches.
- Read latency: `x_ack` toggles, with `x_dout` valid in the same cycle, 1 cycle after `ram_rd_rdy` returns high. A cache hit gives a minimum of about 4 cycles from grant.
- `ram_rd_req` stays high at least until `ram_rd_rdy` is seen low. This guarantees a clean rising edge for the next read.
- INV adds exactly 1 cycle. A new grant is possible in the cycle after INV.
- Back-to-back: IDLE re-arbitrates in the cycle after an ack. No idle bubble is required beyond that.

## Structure
- Package `ddram_arb_pkg`:
  - state enum `{IDLE, WR, RD_LO, RD_HI, INV}`.
  - constants `ADDR_W=28`, `LINE_LSB=3`.
- One sub-module is natural: `rr_arb2`, a 2-input round-robin/fixed-priority grant with a `last` register. Everything else lives in `ddram_arbiter`.

## Test plan
- A writes 0x5A to 0x0000010 → `ram_we_req` toggles once; `a_ack` toggles 1 cycle after `ram_we_ack` matches; `cache_inv` stays 0 (`lr_valid=0`).
- A reads 0x0000010, then B writes 0x0000012 → `cache_inv` pulses once after B's ack. A write to 0x0000020 (line+2) produces no pulse.
- A and B toggle in the same cycle, round-robin, 4 rounds → grants A, B, A, B. With `FIXED_PRIO=1` → A on every round.
- Read with `ddram` model returning `ram_rd_rdy` low for 1 cycle (hit) and for 20 cycles (miss) → `ram_rd_req` drops after low is seen; `x_dout` equals the model byte; only the granted `x_dout` changes.
- Assert `reset` during RD_HI → all outputs at reset values asynchronously. After release, a fresh B read completes normally.

Source files
------------

// File: rtl/ddram_arb_pkg.sv
// Shared types and constants for the ddram two-client arbiter.
package ddram_arb_pkg;

  localparam int unsigned ADDR_W   = 28;
  localparam int unsigned LINE_LSB = 3;
  localparam int unsigned LINE_W   = ADDR_W - LINE_LSB;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_LO,
    RD_HI,
    INV
  } state_t;

  // ddram's line buffer can span the recorded line and the one after it,
  // so a write to either must invalidate; the +1 wraps at the line width.
  function automatic logic line_hit(input logic [LINE_W-1:0] wr_line,
                                    input logic [LINE_W-1:0] lr_line);
    return (wr_line == lr_line) || (wr_line == lr_line + LINE_W'(1));
  endfunction

endpackage

// File: rtl/ddram_arbiter_rr_arb2.sv
// Two-input grant: round-robin on the last served client, or fixed A priority.
module rr_arb2 #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic req_a,
  input  logic req_b,
  input  logic take,
  output logic grant_valid,
  output logic grant_b
);

  logic last_b;

  // Pick a winner; on contention prefer A (fixed) or the client not served last.
  always_comb begin
    grant_valid = req_a | req_b;
    if (req_a && req_b) grant_b = FIXED_PRIO ? 1'b0 : ~last_b;
    else                grant_b = req_b;
  end

  // Remember who was served; resets to B so A wins the first contention.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      last_b <= 1'b1;
    else if (take && grant_valid) last_b <= grant_b;
  end

endmodule

// File: rtl/ddram_arbiter.sv
// Two-client toggle-handshake arbiter and sequencer in front of ddram,
// with line-cache invalidation on writes to the last read line.
module ddram_arbiter
  import ddram_arb_pkg::*;
#(
  parameter int FIXED_PRIO = 0,
  parameter int INV_ENABLE = 1
) (
  input  logic              DDRAM_CLK,
  input  logic              reset,
  input  logic [27:0]       a_addr,
  input  logic [7:0]        a_din,
  input  logic              a_we,
  input  logic              a_req,
  output logic              a_ack,
  output logic [7:0]        a_dout,
  input  logic [27:0]       b_addr,
  input  logic [7:0]        b_din,
  input  logic              b_we,
  input  logic              b_req,
  output logic              b_ack,
  output logic [7:0]        b_dout,
  output logic [27:0]       ram_wraddr,
  output logic [7:0]        ram_din,
  output logic              ram_we_req,
  input  logic              ram_we_ack,
  output logic [27:0]       ram_rdaddr,
  output logic              ram_rd_req,
  input  logic              ram_rd_rdy,
  input  logic [7:0]        ram_dout,
  output logic              cache_inv
);

  state_t              state, state_nx;
  logic                grant_valid, grant_b, take;
  logic                cur_b;
  logic [ADDR_W-1:0]   cur_addr;
  logic [LINE_W-1:0]   lr_line;
  logic                lr_valid;
  logic [ADDR_W-1:0]   g_addr;
  logic [7:0]          g_din;
  logic                g_we;
  logic                wr_done, inv_hit;

  assign take       = (state == IDLE);
  assign wr_done    = (ram_we_ack == ram_we_req);
  assign inv_hit    = (INV_ENABLE != 0) && lr_valid &&
                      line_hit(cur_addr[ADDR_W-1:LINE_LSB], lr_line);
  assign ram_wraddr = cur_addr;
  assign ram_rdaddr = cur_addr;

  rr_arb2 #(
    .FIXED_PRIO (FIXED_PRIO != 0)
  ) u_arb (
    .clk         (DDRAM_CLK),
    .rst         (reset),
    .req_a       (a_req ^ a_ack),
    .req_b       (b_req ^ b_ack),
    .take        (take),
    .grant_valid (grant_valid),
    .grant_b     (grant_b)
  );

  // Steer the granted client's request fields.
  always_comb begin
    g_addr = grant_b ? b_addr : a_addr;
    g_din  = grant_b ? b_din  : a_din;
    g_we   = grant_b ? b_we   : a_we;
  end

  // State register.
  always_ff @(posedge DDRAM_CLK or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state decode.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (grant_valid) state_nx = g_we ? WR : RD_LO;
      WR:      if (wr_done)     state_nx = inv_hit ? INV : IDLE;
      RD_LO:   if (!ram_rd_rdy) state_nx = RD_HI;
      RD_HI:   if (ram_rd_rdy)  state_nx = IDLE;
      INV:                      state_nx = IDLE;
      default:                  state_nx = IDLE;
    endcase
  end

  // Invalidate pulse is a pure function of state.
  always_comb begin
    cache_inv = (state == INV);
  end

  // Request latch, ddram handshakes, client acks/data and last-read-line tracking.
  always_ff @(posedge DDRAM_CLK or posedge reset) begin
    if (reset) begin
      cur_b      <= 1'b0;
      cur_addr   <= '0;
      ram_din    <= '0;
      ram_we_req <= 1'b0;
      ram_rd_req <= 1'b0;
      a_ack      <= 1'b0;
      b_ack      <= 1'b0;
      a_dout     <= '0;
      b_dout     <= '0;
      lr_line    <= '0;
      lr_valid   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (grant_valid) begin
          cur_b    <= grant_b;
          cur_addr <= g_addr;
          if (g_we) begin
            ram_din    <= g_din;
            ram_we_req <= ~ram_we_req;
          end else begin
            ram_rd_req <= 1'b1;
          end
        end
        WR: if (wr_done) begin
          if (cur_b) b_ack <= ~b_ack;
          else       a_ack <= ~a_ack;
        end
        INV: lr_valid <= 1'b0;
        // Holding the request until ready is seen low guarantees ddram a
        // fresh rising edge on the next read.
        RD_LO: if (!ram_rd_rdy) ram_rd_req <= 1'b0;
        RD_HI: if (ram_rd_rdy) begin
          if (cur_b) begin
            b_dout <= ram_dout;
            b_ack  <= ~b_ack;
          end else begin
            a_dout <= ram_dout;
            a_ack  <= ~a_ack;
          end
          lr_line  <= cur_addr[ADDR_W-1:LINE_LSB];
          lr_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ddram_arbiter.sv
// Self-checking bench for ddram_arbiter: a round-robin instance with a
// ddram model (delayed write ack, programmable read-ready low time) and a
// fixed-priority instance with a minimal write-only model.
module tb_ddram_arbiter;

  logic        clk = 1'b0;
  logic        rst;

  // Round-robin instance
  logic [27:0] a_addr, b_addr, ram_wraddr, ram_rdaddr;
  logic [7:0]  a_din, b_din, a_dout, b_dout, ram_din, ram_dout;
  logic        a_we, b_we, a_req, b_req, a_ack, b_ack;
  logic        ram_we_req, ram_we_ack, ram_rd_req, ram_rd_rdy, cache_inv;

  // Fixed-priority instance
  logic [27:0] a2_addr, b2_addr, ram_wraddr2, ram_rdaddr2;
  logic [7:0]  a2_din, b2_din, a2_dout, b2_dout, ram_din2, ram_dout2;
  logic        a2_we, b2_we, a2_req, b2_req, a2_ack, b2_ack;
  logic        ram_we_req2, ram_we_ack2, ram_rd_req2, ram_rd_rdy2, cache_inv2;

  int checks = 0;
  int errors = 0;
  int inv_cnt = 0;
  logic [7:0] exp_a_dout, exp_b_dout;

  always #5 clk = ~clk;

  ddram_arbiter #(.FIXED_PRIO(0), .INV_ENABLE(1)) dut (
    .DDRAM_CLK(clk), .reset(rst),
    .a_addr(a_addr), .a_din(a_din), .a_we(a_we), .a_req(a_req), .a_ack(a_ack), .a_dout(a_dout),
    .b_addr(b_addr), .b_din(b_din), .b_we(b_we), .b_req(b_req), .b_ack(b_ack), .b_dout(b_dout),
    .ram_wraddr(ram_wraddr), .ram_din(ram_din), .ram_we_req(ram_we_req), .ram_we_ack(ram_we_ack),
    .ram_rdaddr(ram_rdaddr), .ram_rd_req(ram_rd_req), .ram_rd_rdy(ram_rd_rdy), .ram_dout(ram_dout),
    .cache_inv(cache_inv)
  );

  ddram_arbiter #(.FIXED_PRIO(1), .INV_ENABLE(1)) dut2 (
    .DDRAM_CLK(clk), .reset(rst),
    .a_addr(a2_addr), .a_din(a2_din), .a_we(a2_we), .a_req(a2_req), .a_ack(a2_ack), .a_dout(a2_dout),
    .b_addr(b2_addr), .b_din(b2_din), .b_we(b2_we), .b_req(b2_req), .b_ack(b2_ack), .b_dout(b2_dout),
    .ram_wraddr(ram_wraddr2), .ram_din(ram_din2), .ram_we_req(ram_we_req2), .ram_we_ack(ram_we_ack2),
    .ram_rdaddr(ram_rdaddr2), .ram_rd_req(ram_rd_req2), .ram_rd_rdy(ram_rd_rdy2), .ram_dout(ram_dout2),
    .cache_inv(cache_inv2)
  );

  // ddram model for the round-robin instance
  logic       we_d1, rd_req_q;
  int         rd_lat = 1;
  int         rd_cnt;
  logic [7:0] rd_byte = 8'h00;
  assign ram_dout = rd_byte;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      we_d1 <= 1'b0; ram_we_ack <= 1'b0; rd_req_q <= 1'b0;
      ram_rd_rdy <= 1'b1; rd_cnt <= 0;
    end else begin
      we_d1      <= ram_we_req;
      ram_we_ack <= we_d1;
      rd_req_q   <= ram_rd_req;
      if (ram_rd_req && !rd_req_q) begin
        ram_rd_rdy <= 1'b0;
        rd_cnt     <= rd_lat;
      end else if (!ram_rd_rdy) begin
        if (rd_cnt <= 1) ram_rd_rdy <= 1'b1;
        rd_cnt <= rd_cnt - 1;
      end
    end
  end

  // Write-only model for the fixed-priority instance
  assign ram_rd_rdy2 = 1'b1;
  assign ram_dout2   = 8'h00;
  always @(posedge clk or posedge rst) begin
    if (rst) ram_we_ack2 <= 1'b0;
    else     ram_we_ack2 <= ram_we_req2;
  end

  always @(negedge clk) if (cache_inv) inv_cnt <= inv_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          cl;       // 0 = A, 1 = B
    bit          we;
    logic [27:0] addr;
    logic [7:0]  data;     // write data or model read byte
    int          lat;      // read-ready low cycles
    int          exp_cyc;  // negedges from request toggle to ack
    int          exp_inv;  // cache_inv pulses expected
  } vec_t;

  task automatic run_txn(input vec_t v);
    int cyc;
    bit done;
    int inv_base;
    rd_lat = v.lat;
    rd_byte = v.we ? 8'h00 : v.data;
    @(negedge clk);
    inv_base = inv_cnt;
    if (v.cl) begin b_addr = v.addr; b_din = v.data; b_we = v.we; b_req = ~b_req; end
    else      begin a_addr = v.addr; a_din = v.data; a_we = v.we; a_req = ~a_req; end
    cyc = 0; done = 1'b0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
      done = v.cl ? (b_ack == b_req) : (a_ack == a_req);
    end
    check("ack_latency", cyc, v.exp_cyc);
    if (!v.we) begin
      if (v.cl) exp_b_dout = v.data; else exp_a_dout = v.data;
    end
    check("a_dout", {24'h0, a_dout}, {24'h0, exp_a_dout});
    check("b_dout", {24'h0, b_dout}, {24'h0, exp_b_dout});
    check("ram_wraddr", {4'h0, ram_wraddr}, {4'h0, v.addr});
    check("ram_rdaddr", {4'h0, ram_rdaddr}, {4'h0, v.addr});
    if (v.we) check("ram_din", {24'h0, ram_din}, {24'h0, v.data});
    check("rd_req_idle", {31'h0, ram_rd_req}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    check("inv_pulses", inv_cnt - inv_base, v.exp_inv);
  endtask

  task automatic issue(input bit d2, input bit ca, input bit cb,
                       input logic [27:0] aa, input logic [27:0] ba);
    if (d2) begin
      if (ca) begin a2_addr = aa; a2_din = aa[7:0]; a2_we = 1'b1; a2_req = ~a2_req; end
      if (cb) begin b2_addr = ba; b2_din = ba[7:0]; b2_we = 1'b1; b2_req = ~b2_req; end
    end else begin
      if (ca) begin a_addr = aa; a_din = aa[7:0]; a_we = 1'b1; a_req = ~a_req; end
      if (cb) begin b_addr = ba; b_din = ba[7:0]; b_we = 1'b1; b_req = ~b_req; end
    end
  endtask

  // Returns 0/1 for the first pending client (A/B) to be acked, 3 on timeout.
  task automatic wait_first(input bit d2, output int who);
    logic pa, pb;
    pa = d2 ? (a2_req != a2_ack) : (a_req != a_ack);
    pb = d2 ? (b2_req != b2_ack) : (b_req != b_ack);
    who = 3;
    for (int c = 0; c < 60 && who == 3; c++) begin
      @(negedge clk);
      if (pa && (d2 ? (a2_req == a2_ack) : (a_req == a_ack)))      who = 0;
      else if (pb && (d2 ? (b2_req == b2_ack) : (b_req == b_ack))) who = 1;
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    a_req = 1'b0; b_req = 1'b0; a2_req = 1'b0; b2_req = 1'b0;
    exp_a_dout = 8'h00; exp_b_dout = 8'h00;
    @(negedge clk);
    rst = 1'b0;
  endtask

  vec_t vecs[10];

  initial begin
    int w;
    vecs[0] = '{1'b0, 1'b1, 28'h0000010, 8'h5A, 1, 4, 0};
    vecs[1] = '{1'b0, 1'b0, 28'h0000010, 8'h3C, 1, 4, 0};
    vecs[2] = '{1'b1, 1'b1, 28'h0000012, 8'hA5, 1, 4, 1};
    vecs[3] = '{1'b0, 1'b1, 28'h0000010, 8'h11, 1, 4, 0};
    vecs[4] = '{1'b1, 1'b0, 28'h0000010, 8'hC3, 20, 23, 0};
    vecs[5] = '{1'b0, 1'b1, 28'h0000020, 8'h22, 1, 4, 0};
    vecs[6] = '{1'b0, 1'b1, 28'h0000018, 8'h33, 1, 4, 1};
    vecs[7] = '{1'b0, 1'b0, 28'hFFFFFFF, 8'h81, 1, 4, 0};
    vecs[8] = '{1'b1, 1'b1, 28'h0000003, 8'h44, 1, 4, 1};
    vecs[9] = '{1'b1, 1'b1, 28'h0000005, 8'h55, 1, 4, 0};

    rst = 1'b1;
    a_addr = '0; a_din = '0; a_we = 1'b0; a_req = 1'b0;
    b_addr = '0; b_din = '0; b_we = 1'b0; b_req = 1'b0;
    a2_addr = '0; a2_din = '0; a2_we = 1'b0; a2_req = 1'b0;
    b2_addr = '0; b2_din = '0; b2_we = 1'b0; b2_req = 1'b0;
    exp_a_dout = 8'h00; exp_b_dout = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_acks", {30'h0, a_ack, b_ack}, 32'h0);
    check("rst_ram_req", {29'h0, ram_we_req, ram_rd_req, cache_inv}, 32'h0);
    check("rst_douts", {16'h0, a_dout, b_dout}, 32'h0);
    check("rst_addr", {4'h0, ram_wraddr}, 32'h0);
    rst = 1'b0;

    foreach (vecs[i]) run_txn(vecs[i]);

    // Simultaneous requests: A then B every round on both instances.
    pulse_reset();
    for (int d = 0; d < 2; d++) begin
      for (int r = 0; r < 4; r++) begin
        @(negedge clk);
        issue(d[0], 1'b1, 1'b1, 28'h100 + 28'(r), 28'h200 + 28'(r));
        @(negedge clk);
        check(d ? "fp_grant_addr" : "rr_grant_addr",
              {4'h0, (d ? ram_wraddr2 : ram_wraddr)}, 32'h100 + 32'(r));
        wait_first(d[0], w);
        check(d ? "fp_first" : "rr_first", w, 0);
        wait_first(d[0], w);
        check(d ? "fp_second" : "rr_second", w, 1);
      end
    end

    // A re-requests the instant it is acked while B waits: round-robin
    // serves B next, fixed priority serves A again.
    for (int d = 0; d < 2; d++) begin
      @(negedge clk);
      issue(d[0], 1'b1, 1'b1, 28'h300, 28'h400);
      wait_first(d[0], w);
      check(d ? "fp_starve_first" : "rr_starve_first", w, 0);
      issue(d[0], 1'b1, 1'b0, 28'h301, 28'h0);
      wait_first(d[0], w);
      check(d ? "fp_starve_next" : "rr_starve_next", w, d ? 0 : 1);
      wait_first(d[0], w);
      check(d ? "fp_starve_last" : "rr_starve_last", w, d ? 1 : 0);
    end

    // Give A a nonzero dout so the async reset check is meaningful.
    run_txn('{1'b0, 1'b0, 28'h0000050, 8'hE7, 1, 4, 0});

    // Asynchronous reset while a B read sits in RD_HI.
    rd_lat = 20; rd_byte = 8'h9E;
    @(negedge clk);
    b_addr = 28'h0000030; b_we = 1'b0; b_req = ~b_req;
    repeat (5) @(negedge clk);
    check("rdhi_req_dropped", {31'h0, ram_rd_req}, 32'h0);
    check("rdhi_pending", {31'h0, (b_ack != b_req)}, 32'h1);
    #2 rst = 1'b1;
    #1;
    check("arst_acks", {30'h0, a_ack, b_ack}, 32'h0);
    check("arst_douts", {16'h0, a_dout, b_dout}, 32'h0);
    check("arst_addr", {4'h0, ram_rdaddr}, 32'h0);
    check("arst_ram", {29'h0, ram_we_req, ram_rd_req, cache_inv}, 32'h0);
    check("arst_din", {24'h0, ram_din}, 32'h0);
    a_req = 1'b0; b_req = 1'b0; a2_req = 1'b0; b2_req = 1'b0;
    exp_a_dout = 8'h00; exp_b_dout = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    run_txn('{1'b1, 1'b0, 28'h0000040, 8'h77, 1, 4, 0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
